// File: rtl/wfa_align_ctrl.sv
// wfa_align_ctrl: top-level alignment sequencer for the WFA tile engine.
// Opens the host load window, seeds the extend FIFO with the origin
// diagonal, dispatches FIFO words to the extend lanes, steps the score
// wavefront by wavefront up to MAX_SCORE and hands off to traceback.
module wfa_align_ctrl #(
    parameter int NUM_EXTEND    = 8,
    parameter int TILE_SIZE     = 512,
    parameter int LOG_TILE_SIZE = $clog2(TILE_SIZE),
    parameter int TB_ADDR       = 10,
    parameter int FIFO_WIDTH    = 2*LOG_TILE_SIZE+TB_ADDR+2,
    parameter int MAX_SCORE     = 255,
    parameter int SCORE_W       = $clog2(MAX_SCORE+1),
    parameter int CYC_W         = 32
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             load,
    input  logic                             start,
    input  logic [LOG_TILE_SIZE:0]           ref_len,
    input  logic [LOG_TILE_SIZE:0]           qry_len,
    output logic                             load_en,
    output logic [NUM_EXTEND*FIFO_WIDTH-1:0] fifo_din,
    output logic                             fifo_wen,
    input  logic                             fifo_full,
    output logic                             fifo_ren,
    input  logic                             fifo_empty,
    input  logic [NUM_EXTEND-1:0]            is_finish,
    input  logic                             reached_end,
    output logic                             wf_next,
    input  logic                             wf_ready,
    output logic                             tb_start,
    input  logic                             tb_done,
    output logic [SCORE_W-1:0]               score,
    output logic [CYC_W-1:0]                 cycles,
    output logic                             busy,
    output logic                             done,
    output logic                             error
);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_SEED, S_ALIGN, S_NEXT, S_TB, S_DONE, S_ERR
    } state_t;

    localparam int DIN_W = NUM_EXTEND*FIFO_WIDTH;
    // Lane-0 origin word: valid=1, is_extend=1, k=0, offset=0, tbAddr=0.
    localparam logic [FIFO_WIDTH-1:0] SEED_WORD = {2'b11, {(FIFO_WIDTH-2){1'b0}}};
    localparam logic [SCORE_W-1:0]    SCORE_MAX = SCORE_W'(MAX_SCORE);

    state_t                   state;
    logic [LOG_TILE_SIZE:0]   ref_q;
    logic [LOG_TILE_SIZE:0]   qry_q;
    logic                     inflight;  // a FIFO read is still propagating into the lanes
    logic                     fl_cnt;    // age of the in-flight read when lanes never drop
    logic                     idle_cnt;  // first drained cycle seen, one more ends the wavefront
    logic                     wf_sent;   // wf_next already issued for this NEXT visit
    logic                     all_fin;
    logic                     lens_ok;
    logic                     drained;

    assign all_fin = &is_finish;
    assign lens_ok = (|ref_q) && (|qry_q);
    assign drained = fifo_empty && all_fin && !inflight;

    // The seed strobe looks at fifo_full in the same cycle, so a write is never
    // issued against a full FIFO and exactly one write is accepted.
    assign fifo_wen = (state == S_SEED) && !fifo_full && lens_ok;
    assign fifo_din = (state == S_SEED) ? DIN_W'(SEED_WORD) : '0;
    // reached_end overrides dispatch, so no read is launched on the way to TB.
    assign fifo_ren = (state == S_ALIGN) && !reached_end && !fifo_empty && all_fin && !inflight;

    assign load_en = (state == S_LOAD);
    assign busy    = (state == S_SEED) || (state == S_ALIGN) || (state == S_NEXT) || (state == S_TB);
    assign done    = (state == S_DONE);
    assign error   = (state == S_ERR);

    // Sequencer FSM with score, cycle counter, read tracking and handshake pulses.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_IDLE;
            ref_q    <= '0;
            qry_q    <= '0;
            score    <= '0;
            cycles   <= '0;
            wf_next  <= 1'b0;
            tb_start <= 1'b0;
            inflight <= 1'b0;
            fl_cnt   <= 1'b0;
            idle_cnt <= 1'b0;
            wf_sent  <= 1'b0;
        end else begin
            wf_next  <= 1'b0;
            tb_start <= 1'b0;
            if (busy && (cycles != '1)) begin
                cycles <= cycles + 1'b1;
            end
            case (state)
                S_IDLE: begin
                    if (load) state <= S_LOAD;
                end
                S_LOAD: begin
                    if (start) begin
                        ref_q  <= ref_len;
                        qry_q  <= qry_len;
                        score  <= '0;
                        cycles <= '0;
                        state  <= ((ref_len == '0) || (qry_len == '0)) ? S_DONE : S_SEED;
                    end
                end
                S_SEED: begin
                    if (fifo_wen) begin
                        state    <= S_ALIGN;
                        inflight <= 1'b0;
                        idle_cnt <= 1'b0;
                    end
                end
                S_ALIGN: begin
                    if (reached_end) begin
                        state    <= S_TB;
                        tb_start <= 1'b1;
                        inflight <= 1'b0;
                        idle_cnt <= 1'b0;
                    end else begin
                        if (fifo_ren) begin
                            inflight <= 1'b1;
                            fl_cnt   <= 1'b0;
                        end else if (inflight) begin
                            if (!all_fin || fl_cnt) inflight <= 1'b0;
                            else                    fl_cnt   <= 1'b1;
                        end
                        if (drained) begin
                            if (idle_cnt) begin
                                state    <= S_NEXT;
                                idle_cnt <= 1'b0;
                                wf_sent  <= 1'b0;
                            end else begin
                                idle_cnt <= 1'b1;
                            end
                        end else begin
                            idle_cnt <= 1'b0;
                        end
                    end
                end
                S_NEXT: begin
                    if (reached_end) begin
                        state    <= S_TB;
                        tb_start <= 1'b1;
                    end else if (!wf_sent) begin
                        if (score == SCORE_MAX) begin
                            state <= S_ERR;
                        end else begin
                            score   <= score + 1'b1;
                            wf_next <= 1'b1;
                            wf_sent <= 1'b1;
                        end
                    end else if (wf_ready) begin
                        state    <= S_ALIGN;
                        inflight <= 1'b0;
                        idle_cnt <= 1'b0;
                    end
                end
                S_TB: begin
                    if (tb_done) state <= S_DONE;
                end
                S_DONE, S_ERR: begin
                    if (load) state <= S_LOAD;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wfa_align_ctrl.sv
// tb_wfa_align_ctrl: self-checking bench for wfa_align_ctrl with a small
// FIFO / extend-lane / traceback responder and a result scoreboard.
module tb_wfa_align_ctrl;

    localparam int NE   = 8;
    localparam int LT   = 9;
    localparam int FW   = 2*LT+10+2;
    localparam int DW   = NE*FW;
    localparam int MAXS = 4;
    localparam int SW   = 3;
    localparam int CW   = 32;

    logic          clk = 1'b0;
    logic          rst, load, start;
    logic [LT:0]   ref_len, qry_len;
    logic          load_en, fifo_wen, fifo_ren, fifo_full, fifo_empty;
    logic [DW-1:0] fifo_din;
    logic [NE-1:0] is_finish;
    logic          reached_end, wf_next, wf_ready, tb_start, tb_done;
    logic [SW-1:0] score;
    logic [CW-1:0] cycles;
    logic          busy, done, error;

    wfa_align_ctrl #(.NUM_EXTEND(NE), .TILE_SIZE(512), .TB_ADDR(10), .MAX_SCORE(MAXS), .CYC_W(CW)) dut (
        .clk(clk), .rst(rst), .load(load), .start(start),
        .ref_len(ref_len), .qry_len(qry_len), .load_en(load_en),
        .fifo_din(fifo_din), .fifo_wen(fifo_wen), .fifo_full(fifo_full),
        .fifo_ren(fifo_ren), .fifo_empty(fifo_empty), .is_finish(is_finish),
        .reached_end(reached_end), .wf_next(wf_next), .wf_ready(wf_ready),
        .tb_start(tb_start), .tb_done(tb_done), .score(score), .cycles(cycles),
        .busy(busy), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    typedef struct {
        int score; int done; int error; int wen; int wfn; int tbs;
    } exp_t;
    exp_t sb[$];

    int n_chk = 0, n_err = 0;
    int cyc_now = 0, cyc_start = 0;
    int fifo_cnt = 0, lane_t = 0, end_t = 0, rdy_t = 0, tbd_t = 0, ren_goal = 0;
    int wen_cnt = 0, ren_cnt = 0, wfn_cnt = 0, tbs_cnt = 0, both_cnt = 0;
    logic s_wen = 0, s_ren = 0, s_wfn = 0, s_tbs = 0;
    logic [DW-1:0] s_din = '0, din_cap = '0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_chk++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    // Responder: FIFO occupancy, lane busy time, reached_end/wf_ready/tb_done timing.
    initial begin
        fifo_empty = 1'b1; is_finish = '1; reached_end = 0; wf_ready = 0; tb_done = 0;
        forever begin
            @(negedge clk);
            cyc_now++;
            if (!rst) begin
                fifo_cnt = 0; lane_t = 0; end_t = 0; rdy_t = 0; tbd_t = 0;
                is_finish = '1; reached_end = 0; wf_ready = 0; tb_done = 0;
                s_wen = 0; s_ren = 0; s_wfn = 0; s_tbs = 0;
            end else begin
                if (lane_t > 0) begin lane_t--; if (lane_t == 0) is_finish = '1; end
                if (end_t > 0) begin end_t--; reached_end = (end_t == 0); end else reached_end = 0;
                if (rdy_t > 0) begin
                    rdy_t--;
                    if (rdy_t == 0) begin wf_ready = 1; fifo_cnt++; end
                end else wf_ready = 0;
                if (tbd_t > 0) begin tbd_t--; tb_done = (tbd_t == 0); end else tb_done = 0;
                if (s_wen && s_ren) both_cnt++;
                if (s_wen) begin fifo_cnt++; wen_cnt++; if (wen_cnt == 1) din_cap = s_din; end
                if (s_ren) begin
                    if (fifo_cnt > 0) fifo_cnt--;
                    ren_cnt++; is_finish = '0; lane_t = 3;
                    if (ren_cnt == ren_goal) end_t = 4;
                end
                if (s_wfn) begin wfn_cnt++; rdy_t = 3; end
                if (s_tbs) begin tbs_cnt++; tbd_t = 2; end
            end
            fifo_empty = (fifo_cnt == 0);
            #3;
            s_wen = fifo_wen; s_ren = fifo_ren; s_wfn = wf_next; s_tbs = tb_start; s_din = fifo_din;
        end
    end

    task automatic wait_complete(input int budget);
        exp_t e;
        int k = 0;
        while (!(done || error) && k < budget) begin
            @(negedge clk); #1;
            k++;
        end
        check("complete", done || error, 1);
        if (sb.size() == 0) begin
            check("sb_underflow", 0, 1);
        end else begin
            e = sb.pop_front();
            check("score", score, e.score);
            check("done", done, e.done);
            check("error", error, e.error);
            check("seed_writes", wen_cnt, e.wen);
            check("wf_next_pulses", wfn_cnt, e.wfn);
            check("tb_start_pulses", tbs_cnt, e.tbs);
            check("cycles", cycles, cyc_now - cyc_start - 1);
        end
    endtask

    task automatic begin_run(input int rl, input int ql, input int goal, input int full_cyc);
        load = 1;
        @(negedge clk); #1;
        load = 0;
        check("load_en", load_en, 1);
        ref_len = rl[LT:0]; qry_len = ql[LT:0]; start = 1; fifo_full = (full_cyc > 0);
        wen_cnt = 0; ren_cnt = 0; wfn_cnt = 0; tbs_cnt = 0; ren_goal = goal; cyc_start = cyc_now;
        @(negedge clk); #1;
        start = 0;
    endtask

    task automatic run_flow(input int rl, input int ql, input int goal, input int full_cyc, input exp_t e);
        sb.push_back(e);
        begin_run(rl, ql, goal, full_cyc);
        if (full_cyc > 0) begin
            repeat (full_cyc) begin @(negedge clk); #1; end
            check("bp_no_write", wen_cnt, 0);
            fifo_full = 0;
            @(negedge clk); #1;
            check("bp_one_write", wen_cnt, 1);
        end
        wait_complete(600);
    endtask

    logic [FW-1:0] seed_exp;

    initial begin
        int k;
        rst = 0; load = 0; start = 0; ref_len = '0; qry_len = '0; fifo_full = 0;
        seed_exp = '0; seed_exp[FW-1] = 1'b1; seed_exp[FW-2] = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        check("rst_ctl", {load_en, fifo_wen, fifo_ren, wf_next, tb_start, busy, done, error}, 0);
        check("rst_score", score, 0);
        check("rst_cycles", cycles, 0);
        check("rst_din", |fifo_din, 0);
        rst = 1;
        @(negedge clk); #1;

        // basic flow
        run_flow(8, 8, 1, 0, '{score:0, done:1, error:0, wen:1, wfn:0, tbs:1});
        check("seed_lane0", din_cap[FW-1:0], seed_exp);
        check("seed_upper", |din_cap[DW-1:FW], 0);
        start = 1; ref_len = 8; qry_len = 8;
        @(negedge clk); #1;
        start = 0;
        repeat (2) begin @(negedge clk); #1; end
        check("done_hold", done, 1);
        check("start_ignored", wen_cnt, 1);

        // score iteration
        run_flow(8, 8, 4, 0, '{score:3, done:1, error:0, wen:1, wfn:3, tbs:1});
        // backpressure in SEED
        run_flow(16, 12, 1, 10, '{score:0, done:1, error:0, wen:1, wfn:0, tbs:1});
        // overflow at MAX_SCORE
        run_flow(8, 8, 0, 0, '{score:MAXS, done:0, error:1, wen:1, wfn:MAXS, tbs:0});
        load = 1;
        @(negedge clk); #1;
        load = 0;
        check("err_clear", error, 0);
        check("err_load_en", load_en, 1);
        // zero length
        run_flow(8, 0, 1, 0, '{score:0, done:1, error:0, wen:0, wfn:0, tbs:0});

        // async reset in ALIGN at score 2
        begin_run(8, 8, 0, 0);
        k = 0;
        while (!(score == 2 && ren_cnt == 3) && k < 400) begin
            @(negedge clk); #1;
            k++;
        end
        check("pre_rst_score", score, 2);
        check("pre_rst_busy", busy, 1);
        #1 rst = 0;
        #1;
        check("arst_ctl", {load_en, fifo_wen, fifo_ren, wf_next, tb_start, busy, done, error}, 0);
        check("arst_score", score, 0);
        check("arst_cycles", cycles, 0);
        check("arst_din", |fifo_din, 0);
        @(negedge clk); #1;
        rst = 1;
        @(negedge clk); #1;
        check("post_rst_idle", {busy, load_en, done, error}, 0);
        run_flow(8, 8, 1, 0, '{score:0, done:1, error:0, wen:1, wfn:0, tbs:1});

        check("wen_ren_overlap", both_cnt, 0);
        check("sb_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

    // Hard stop if the flow ever hangs.
    initial begin
        #300000;
        $display("FAIL watchdog: got 0 expected 1");
        $fatal(1, "watchdog expired");
    end

endmodule
